// File: rtl/handshake_pkg.sv
// handshake_pkg: shared definitions for both halves of the four-phase
// req/ack clock-domain-crossing handshake.
//   - hs_state_e          : source-side FSM state encoding (2 bits)
//   - HS_DATA_W_DEF       : default width of the transferred word
//   - HS_SYNC_STAGES_DEF  : default synchronizer depth (minimum 2)
package handshake_pkg;

    localparam int HS_DATA_W_DEF      = 8;
    localparam int HS_SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DROP = 2'b10
    } hs_state_e;

endpackage

// File: rtl/sync_bit.sv
// sync_bit: single-bit multi-flop synchronizer with async active-low reset.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, clears every stage to 0
//   i_d     : asynchronous input bit
//   o_q     : input after SYNC_STAGES flops of i_clk
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    if (SYNC_STAGES < 2) begin : g_bad_depth
        $error("sync_bit: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_chain <= '0;
        else          r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/send_fsm.sv
// send_fsm: source-domain (aclk) half of a four-phase req/ack CDC handshake.
// Captures a word on an accepted asend, holds it on adata, raises req, waits
// for the synchronized ack to rise and then fall, and pulses adone on retire.
// Ports:
//   aclk, arst_n : source clock, async active-low reset
//   asend        : load strobe, honoured only while aready=1
//   adata_in     : word sampled on the honoured asend
//   aready       : idle and able to accept asend
//   adone        : one-cycle pulse when the transfer retires
//   req          : registered request toward the destination domain
//   adata        : held data bus toward the destination domain
//   ack          : destination acknowledge, asynchronous to aclk
module send_fsm
    import handshake_pkg::*;
#(
    parameter int DATA_W      = HS_DATA_W_DEF,
    parameter int SYNC_STAGES = HS_SYNC_STAGES_DEF
) (
    input  logic              aclk,
    input  logic              arst_n,
    input  logic              asend,
    input  logic [DATA_W-1:0] adata_in,
    output logic              aready,
    output logic              adone,
    output logic              req,
    output logic [DATA_W-1:0] adata,
    input  logic              ack
);

    hs_state_e         r_state;
    logic              r_req;
    logic              r_adone;
    logic              r_aready;
    logic [DATA_W-1:0] r_adata;
    logic              w_ack_s;

    // Raw ack is only ever seen through this synchronizer.
    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk   (aclk),
        .i_rst_n (arst_n),
        .i_d     (ack),
        .o_q     (w_ack_s)
    );

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_adone  <= 1'b0;
            r_aready <= 1'b1;
            r_adata  <= '0;
        end else begin
            r_adone <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A stale ack_s here is ignored; REQ waits for it anyway.
                    if (asend) begin
                        r_adata  <= adata_in;
                        r_req    <= 1'b1;
                        r_aready <= 1'b0;
                        r_state  <= REQ;
                    end
                end
                REQ: begin
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    // adone and aready rise together on IDLE re-entry so a
                    // new asend can be presented in the adone cycle.
                    if (!w_ack_s) begin
                        r_adone  <= 1'b1;
                        r_aready <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_req    <= 1'b0;
                    r_aready <= 1'b1;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign req    = r_req;
    assign adata  = r_adata;
    assign adone  = r_adone;
    assign aready = r_aready;

endmodule

// File: tb/tb_send_fsm.sv
module tb_send_fsm;
    localparam int DW = 8;
    localparam int SS = 2;

    logic          aclk = 1'b0;
    logic          arst_n = 1'b0;
    logic          asend = 1'b0;
    logic [DW-1:0] adata_in = '0;
    logic          aready, adone, req;
    logic [DW-1:0] adata;
    logic          ack = 1'b0;

    send_fsm #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .aclk(aclk), .arst_n(arst_n), .asend(asend), .adata_in(adata_in),
        .aready(aready), .adone(adone), .req(req), .adata(adata), .ack(ack)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;

    // Transaction-level reference: busy / ack-seen-high flags plus the ack
    // history as a delay queue of SS edges.
    logic          m_req, m_done, m_busy, m_hi;
    logic [DW-1:0] m_adata;
    logic          ackq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_done = 0; m_busy = 0; m_hi = 0; m_adata = '0;
        ackq.delete();
        for (int i = 0; i < SS; i++) ackq.push_back(1'b0);
    endtask

    task automatic tick();
        logic acks;
        acks = ackq.pop_front();
        ackq.push_back(ack);
        m_done = 0;
        if (!m_busy) begin
            if (asend) begin
                m_adata = adata_in; m_req = 1; m_busy = 1; m_hi = 0;
            end
        end else if (!m_hi) begin
            if (acks) begin m_req = 0; m_hi = 1; end
        end else if (!acks) begin
            m_done = 1; m_busy = 0;
        end
        @(posedge aclk); #1;
        chk("req", req, m_req);
        chk("adata", adata, m_adata);
        chk("adone", adone, m_done);
        chk("aready", aready, !m_busy);
        if (adone) n_done++;
    endtask

    task automatic do_reset(input int n);
        arst_n = 0; asend = 0; ack = 0;
        repeat (n) @(posedge aclk);
        #1 arst_n = 1;
        model_reset();
    endtask

    // One handshake: ack rises hi cycles after req rises, falls lo cycles
    // after req falls; optionally pokes asend with 8'h3C while busy.
    task automatic run_xfer(input logic [DW-1:0] d, input int hi, input int lo, input bit poke);
        int n;
        int d0;
        d0 = n_done;
        asend = 1; adata_in = d;
        tick();
        asend = 0;
        chk("req_rise", req, 1);
        for (int i = 0; i < hi; i++) begin
            if (poke) begin asend = 1; adata_in = 8'h3C; end
            tick();
        end
        asend = 0;
        ack = 1;
        n = 0;
        while (req && n < 20) begin tick(); n++; end
        chk("req_fall_lat", n, SS + 1);
        for (int i = 0; i < lo; i++) begin
            if (poke) begin asend = 1; adata_in = 8'h3C; end
            tick();
            chk("hold_adata", adata, d);
        end
        asend = 0;
        ack = 0;
        n = 0;
        while (!adone && n < 20) begin tick(); n++; end
        chk("adone_seen", adone, 1);
        chk("aready_on_done", aready, 1);
        chk("xfer_adata", adata, d);
        chk("done_count", n_done - d0, 1);
    endtask

    initial begin
        int n;
        int d0;
        model_reset();
        // Reset then idle.
        do_reset(3);
        chk("rst_req", req, 0);
        chk("rst_adata", adata, 0);
        chk("rst_aready", aready, 1);
        chk("rst_adone", adone, 0);
        repeat (10) tick();

        // Single transfer, then one with busy-time asend pokes.
        run_xfer(8'hA5, 5, 4, 1'b0);
        run_xfer(8'hA5, 5, 4, 1'b1);
        tick();
        chk("no_extra_xfer", aready, 1);

        // Back-to-back: next asend presented in the adone cycle.
        run_xfer(8'h11, 3, 2, 1'b0);
        run_xfer(8'h22, 3, 2, 1'b0);
        chk("b2b_last", adata, 8'h22);

        // Reset mid-REQ: clears asynchronously, no clock needed.
        asend = 1; adata_in = 8'h99;
        tick();
        asend = 0;
        tick(); tick();
        #2 arst_n = 0;
        #1;
        chk("async_req", req, 0);
        chk("async_adata", adata, 0);
        chk("async_aready", aready, 1);
        @(posedge aclk); #1 arst_n = 1;
        model_reset();
        tick();
        run_xfer(8'h7E, 4, 3, 1'b0);

        // Stale ack: held high before the transfer starts.
        ack = 1;
        repeat (4) tick();
        chk("stale_idle", aready, 1);
        d0 = n_done;
        asend = 1; adata_in = 8'h55;
        tick();
        asend = 0;
        chk("stale_req", req, 1);
        n = 0;
        while (req && n < 20) begin tick(); n++; end
        chk("stale_to_drop", req, 0);
        repeat (5) tick();
        chk("stale_wait_drop", aready, 0);
        ack = 0;
        n = 0;
        while (!adone && n < 20) begin tick(); n++; end
        chk("stale_done", n_done - d0, 1);

        // Randomized traffic against the reference.
        for (int i = 0; i < 800; i++) begin
            asend = ($urandom_range(0, 3) == 0);
            adata_in = DW'($urandom);
            if ($urandom_range(0, 4) == 0) ack = ~ack;
            tick();
        end
        asend = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
